// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan controller family.
// Font is hex 0..F with bit 6 = segment a through bit 0 = segment g.
package seg7_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StBlank,
      StOn
   } scan_state_e;

   localparam int unsigned PWM_PERIOD = 15;

   // Packed so that SEG_FONT[n] is the pattern for nibble n.
   localparam logic [15:0][6:0] SEG_FONT = {
      7'h47, 7'h4F, 7'h3D, 7'h4E,  // F E d C
      7'h1F, 7'h77, 7'h7B, 7'h7F,  // b A 9 8
      7'h70, 7'h5F, 7'h5B, 7'h33,  // 7 6 5 4
      7'h79, 7'h6D, 7'h30, 7'h7E   // 3 2 1 0
   };

   function automatic logic [6:0] font_lookup(input logic [3:0] nibble);
      return SEG_FONT[nibble];
   endfunction

endpackage

// File: rtl/seg7_font_rom.sv
// Registered hex-nibble to a..g segment lookup with an output gate.
// A low gate registers all segments dark regardless of the nibble.
module seg7_font_rom
   import seg7_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] nibble,
   input  logic       gate,
   output logic [6:0] seg
);

   logic [6:0] seg_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_q <= '0;
      end else if (gate) begin
         seg_q <= font_lookup(nibble);
      end else begin
         seg_q <= '0;
      end
   end

   assign seg = seg_q;

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a common-cathode seven-segment display with
// dead-time blanking, per-digit PWM brightness and frame-synchronous data updates.
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int unsigned DIGITS = 4,
   parameter int unsigned DWELL  = 1000,
   parameter int unsigned BLANK  = 8,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic [3:0]            brightness,
   input  logic                  load_valid,
   input  logic [4*DIGITS-1:0]   load_data,
   input  logic [DIGITS-1:0]     load_blank,
   output logic                  load_ready,
   output logic [6:0]            seg,
   output logic [DIGITS-1:0]     digit_sel,
   output logic                  frame_done
);

   localparam int unsigned      IDX_W      = $clog2(DIGITS);
   localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(DWELL - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);
   localparam logic [CNT_W-1:0] ON_CNT     = CNT_W'(BLANK);
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DIGITS - 1);
   localparam logic [3:0]       PWM_LAST   = 4'(PWM_PERIOD - 1);

   scan_state_e          state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [3:0]           pwm_q, pwm_d;
   logic [3:0]           bright_q, bright_d;
   logic [DIGITS-1:0]    sel_q, sel_d;
   logic                 fd_q, fd_d;

   logic                 empty_q, empty_d;
   logic [4*DIGITS-1:0]  shadow_data_q, shadow_data_d;
   logic [DIGITS-1:0]    shadow_blank_q, shadow_blank_d;
   logic [4*DIGITS-1:0]  act_data_q, act_data_d;
   logic [DIGITS-1:0]    act_blank_q, act_blank_d;

   logic                 accept;
   logic                 copy;
   logic [3:0]           rom_nibble;
   logic                 rom_gate;

   // Scan sequencing: slot counter runs 0..DWELL-1, BLANK first, ON for the rest.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      pwm_d    = pwm_q;
      bright_d = bright_q;
      if (!en) begin
         state_d = StIdle;
         cnt_d   = '0;
         idx_d   = '0;
         pwm_d   = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               state_d = StBlank;
               cnt_d   = '0;
               idx_d   = '0;
            end
            StBlank: begin
               if (cnt_q == BLANK_LAST) begin
                  state_d  = StOn;
                  cnt_d    = ON_CNT;
                  pwm_d    = '0;
                  bright_d = brightness;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            StOn: begin
               pwm_d = (pwm_q == PWM_LAST) ? 4'd0 : pwm_q + 1'b1;
               if (cnt_q == LAST_CNT) begin
                  state_d = StBlank;
                  cnt_d   = '0;
                  pwm_d   = '0;
                  idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // Shadow is only ever copied while full and only ever filled while empty,
   // so an accept on the frame_done cycle is held for the following boundary.
   assign accept = load_valid && empty_q;
   assign copy   = !empty_q && (fd_q || (state_q == StIdle));

   always_comb begin
      empty_d        = empty_q;
      shadow_data_d  = shadow_data_q;
      shadow_blank_d = shadow_blank_q;
      act_data_d     = act_data_q;
      act_blank_d    = act_blank_q;
      if (copy) begin
         act_data_d  = shadow_data_q;
         act_blank_d = shadow_blank_q;
         empty_d     = 1'b1;
      end
      if (accept) begin
         shadow_data_d  = load_data;
         shadow_blank_d = load_blank;
         empty_d        = 1'b0;
      end
   end

   // Outputs are registered from next-state values so they line up with the state.
   always_comb begin
      rom_nibble = act_data_q[{idx_d, 2'b00} +: 4];
      rom_gate   = (state_d == StOn) && !act_blank_q[idx_d] && (pwm_d < bright_d);
      fd_d       = (state_d == StOn) && (idx_d == LAST_IDX) && (cnt_d == LAST_CNT);
      sel_d      = '1;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if ((state_d == StOn) && (idx_d == IDX_W'(i))) begin
            sel_d[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= StIdle;
         cnt_q          <= '0;
         idx_q          <= '0;
         pwm_q          <= '0;
         bright_q       <= '0;
         sel_q          <= '1;
         fd_q           <= 1'b0;
         empty_q        <= 1'b1;
         shadow_data_q  <= '0;
         shadow_blank_q <= '0;
         act_data_q     <= '0;
         act_blank_q    <= '1;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         idx_q          <= idx_d;
         pwm_q          <= pwm_d;
         bright_q       <= bright_d;
         sel_q          <= sel_d;
         fd_q           <= fd_d;
         empty_q        <= empty_d;
         shadow_data_q  <= shadow_data_d;
         shadow_blank_q <= shadow_blank_d;
         act_data_q     <= act_data_d;
         act_blank_q    <= act_blank_d;
      end
   end

   seg7_font_rom u_font_rom (
      .clk    (clk),
      .rst_n  (rst_n),
      .nibble (rom_nibble),
      .gate   (rom_gate),
      .seg    (seg)
   );

   assign load_ready = empty_q;
   assign digit_sel  = sel_q;
   assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: a frame-position model pushes expected outputs each edge,
// a negedge monitor pops and compares; directed checks cover timing and boundaries.
module tb_seg7_scan_ctrl;

   localparam int DIGITS = 4;
   localparam int DWELL  = 16;
   localparam int BLANK  = 2;
   localparam int FRAME  = DIGITS * DWELL;

   logic        clk        = 1'b0;
   logic        rst_n      = 1'b0;
   logic        en         = 1'b0;
   logic [3:0]  brightness = 4'd0;
   logic        load_valid = 1'b0;
   logic [15:0] load_data  = 16'h0;
   logic [3:0]  load_blank = 4'h0;
   logic        load_ready;
   logic [6:0]  seg;
   logic [3:0]  digit_sel;
   logic        frame_done;

   always #5 clk = ~clk;

   seg7_scan_ctrl #(
      .DIGITS (DIGITS),
      .DWELL  (DWELL),
      .BLANK  (BLANK),
      .CNT_W  (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .brightness (brightness),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_blank (load_blank),
      .load_ready (load_ready),
      .seg        (seg),
      .digit_sel  (digit_sel),
      .frame_done (frame_done)
   );

   typedef struct packed {
      logic [6:0] seg;
      logic [3:0] sel;
      logic       fd;
      logic       rdy;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   logic [6:0] font_tbl [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

   // Reference model: position within the frame since the enabling edge.
   bit          m_run   = 1'b0;
   int          m_t     = 0;
   logic [15:0] m_act   = 16'h0;
   logic [3:0]  m_amask = 4'hF;
   logic [15:0] m_sh    = 16'h0;
   logic [3:0]  m_shm   = 4'h0;
   bit          m_full  = 1'b0;
   logic [3:0]  m_bq    = 4'd0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
      end
   endtask

   task automatic model_reset();
      m_run   = 1'b0;
      m_t     = 0;
      m_act   = 16'h0;
      m_amask = 4'hF;
      m_sh    = 16'h0;
      m_shm   = 4'h0;
      m_full  = 1'b0;
      m_bq    = 4'd0;
      exp_q.delete();
   endtask

   task automatic model_step();
      bit was_idle;
      bit was_fd;
      bit full0;
      was_idle = !m_run;
      was_fd   = m_run && (m_t == FRAME - 1);
      full0    = m_full;
      if (full0 && (was_idle || was_fd)) begin
         m_act   = m_sh;
         m_amask = m_shm;
         m_full  = 1'b0;
      end
      if (!full0 && load_valid) begin
         m_sh   = load_data;
         m_shm  = load_blank;
         m_full = 1'b1;
      end
      if (!en) begin
         m_run = 1'b0;
         m_t   = 0;
      end else if (!m_run) begin
         m_run = 1'b1;
         m_t   = 0;
      end else begin
         m_t = (m_t + 1) % FRAME;
      end
      if (m_run && (m_t % DWELL) == BLANK) m_bq = brightness;
   endtask

   function automatic exp_t model_expect();
      exp_t       e;
      int         slot;
      int         ph;
      int         pwm;
      logic [3:0] nib;
      e.fd  = m_run && (m_t == FRAME - 1);
      e.rdy = !m_full;
      e.seg = 7'h0;
      e.sel = 4'hF;
      if (m_run) begin
         slot = m_t / DWELL;
         ph   = m_t % DWELL;
         if (ph >= BLANK) begin
            e.sel = ~(4'b0001 << slot);
            pwm   = (ph - BLANK) % 15;
            nib   = m_act[slot*4 +: 4];
            if (pwm < int'(m_bq) && !m_amask[slot]) e.seg = font_tbl[nib];
         end
      end
      return e;
   endfunction

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         model_reset();
      end else begin
         model_step();
         exp_q.push_back(model_expect());
      end
   end

   initial forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check("seg", 32'(seg), 32'(e.seg));
         check("digit_sel", 32'(digit_sel), 32'(e.sel));
         check("frame_done", 32'(frame_done), 32'(e.fd));
         check("load_ready", 32'(load_ready), 32'(e.rdy));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_sel(input logic [3:0] target);
      int k = 0;
      @(negedge clk);
      while (digit_sel !== target && k < 300) begin
         @(negedge clk);
         k++;
      end
      check("wait_sel", 32'(digit_sel), 32'(target));
   endtask

   task automatic wait_fd();
      int k = 0;
      @(negedge clk);
      while (frame_done !== 1'b1 && k < 300) begin
         @(negedge clk);
         k++;
      end
      check("wait_fd", 32'(frame_done), 32'd1);
   endtask

   task automatic fd_period();
      int k = 0;
      wait_fd();
      do begin
         @(negedge clk);
         k++;
      end while (frame_done !== 1'b1 && k < 200);
      check("fd_period", 32'(k), 32'(FRAME));
   endtask

   task automatic load(input logic [15:0] data, input logic [3:0] mask);
      int k = 0;
      while (load_ready !== 1'b1 && k < 200) begin
         tick(1);
         k++;
      end
      check("load_wait", 32'(load_ready), 32'd1);
      load_valid = 1'b1;
      load_data  = data;
      load_blank = mask;
      tick(1);
      load_valid = 1'b0;
   endtask

   task automatic count_lit(input int want);
      int n = 0;
      wait_fd();
      repeat (DWELL) begin
         @(negedge clk);
         if (digit_sel == 4'b1110 && seg != 7'h0) n++;
      end
      check("lit_cnt", 32'(n), 32'(want));
   endtask

   initial begin
      int dark;
      int scanned;

      tick(3);
      check("rst_seg", 32'(seg), 32'h0);
      check("rst_sel", 32'(digit_sel), 32'hF);
      check("rst_rdy", 32'(load_ready), 32'h1);
      check("rst_fd", 32'(frame_done), 32'h0);
      rst_n = 1'b1;
      tick(100);

      load(16'h1234, 4'h0);
      tick(2);
      brightness = 4'd15;
      en         = 1'b1;
      fd_period();
      tick(10);

      // Mid-frame update is held until the frame boundary.
      wait_sel(4'b1101);
      load(16'hABCD, 4'h0);
      check("rdy_low", 32'(load_ready), 32'h0);
      wait_fd();
      check("rdy_at_fd", 32'(load_ready), 32'h0);
      @(negedge clk);
      check("rdy_after_fd", 32'(load_ready), 32'h1);

      brightness = 4'd8;
      count_lit(8);
      brightness = 4'd0;
      count_lit(0);
      brightness = 4'd15;
      count_lit(14);

      load(16'h1234, 4'b0100);
      wait_fd();
      dark    = 0;
      scanned = 0;
      repeat (FRAME) begin
         @(negedge clk);
         if (digit_sel == 4'b1011) begin
            scanned++;
            if (seg != 7'h0) dark++;
         end
      end
      check("mask_dark", 32'(dark), 32'h0);
      check("mask_scanned", 32'(scanned), 32'(DWELL - BLANK));

      wait_sel(4'b1101);
      en = 1'b0;
      @(negedge clk);
      check("idle_sel", 32'(digit_sel), 32'hF);
      check("idle_seg", 32'(seg), 32'h0);
      tick(5);
      en = 1'b1;
      wait_sel(4'b1110);
      check("restart_seg", 32'(seg), 32'h33);
      tick(20);

      // Asynchronous reset mid-ON with a load pending.
      wait_sel(4'b1101);
      load(16'h5678, 4'h0);
      check("pend_rdy", 32'(load_ready), 32'h0);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_seg", 32'(seg), 32'h0);
      check("arst_sel", 32'(digit_sel), 32'hF);
      check("arst_fd", 32'(frame_done), 32'h0);
      check("arst_rdy", 32'(load_ready), 32'h1);
      tick(2);
      rst_n = 1'b1;
      tick(FRAME + 20);
      en = 1'b0;
      tick(4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
